// File: rtl/threshold_binarizer.sv
// rtl/threshold_binarizer.sv - per-pixel ROM-threshold binarizer with frame tracking (option: THRESH_OFFSET_EN)
module threshold_binarizer #(
    parameter int ADDR_W      = 14,
    parameter int PIX_W       = 8,
    parameter int NUM_PIXELS  = 16384,
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
`ifdef THRESH_OFFSET_EN
    input  logic [PIX_W:0]    thr_offset,
`endif
    output logic              out_valid,
    output logic              out_bin,
    output logic              out_sof,
    output logic              out_eof,
    output logic              err_sync
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    // Acceptance decode for the pixel presented this cycle
    logic              acc;
    logic              acc_sof;
    logic              acc_eof;
    logic [ADDR_W-1:0] acc_idx;

    // Delay line: stage k holds the pixel accepted k cycles ago
    logic [ROM_LATENCY-1:0] dv_q;
    logic [ROM_LATENCY-1:0] ds_q;
    logic [ROM_LATENCY-1:0] de_q;
    logic [PIX_W-1:0]       dp_q [ROM_LATENCY];

    // Compare stage
    logic [PIX_W-1:0] thr_eff;
    logic             bin_d;

    logic out_valid_q;
    logic out_bin_q;
    logic out_sof_q;
    logic out_eof_q;

    // A starting pixel always reads threshold 0; otherwise the running index
    always_comb begin
        rom_addr = cnt_q;
        if (in_valid && in_sof) begin
            rom_addr = '0;
        end
    end

    // Frame FSM next state: accept/discard, index counting, framing errors
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc     = 1'b0;
        acc_sof = 1'b0;
        acc_eof = 1'b0;
        acc_idx = cnt_q;
        if (in_valid) begin
            if (in_sof) begin
                acc     = 1'b1;
                acc_sof = 1'b1;
                acc_idx = '0;
                // A new frame before the previous one finished
                if (state_q == RUN) begin
                    err_d = 1'b1;
                end
            end else if (state_q == RUN) begin
                acc = 1'b1;
            end else begin
                // Pixel outside any frame is dropped
                err_d = 1'b1;
            end
            if (acc) begin
                if (acc_idx == LAST_IDX) begin
                    acc_eof = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = acc_idx + ADDR_W'(1);
                    state_d = RUN;
                end
            end
        end
    end

    // Frame FSM state, counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Delay line so the pixel arrives with the ROM data for its address
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q <= '0;
            ds_q <= '0;
            de_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dp_q[i] <= '0;
            end
        end else begin
            dv_q[0] <= acc;
            ds_q[0] <= acc & acc_sof;
            de_q[0] <= acc & acc_eof;
            dp_q[0] <= in_pixel;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                dv_q[i] <= dv_q[i-1];
                ds_q[i] <= ds_q[i-1];
                de_q[i] <= de_q[i-1];
                dp_q[i] <= dp_q[i-1];
            end
        end
    end

`ifdef THRESH_OFFSET_EN
    logic signed [PIX_W+1:0] thr_sum;

    // Offset-adjusted threshold, clamped to the pixel range
    always_comb begin
        thr_sum = $signed({2'b00, rom_q}) + $signed({thr_offset[PIX_W], thr_offset});
        thr_eff = thr_sum[PIX_W-1:0];
        if (thr_sum[PIX_W+1]) begin
            thr_eff = '0;
        end else if (thr_sum[PIX_W]) begin
            thr_eff = '1;
        end
    end
`else
    // Threshold taken directly from the ROM
    always_comb begin
        thr_eff = rom_q;
    end
`endif

    // Strictly-greater unsigned compare, gated by the stage valid
    always_comb begin
        bin_d = dv_q[ROM_LATENCY-1] & (dp_q[ROM_LATENCY-1] > thr_eff);
    end

    // Registered outputs; markers only ever qualify a valid pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_bin_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= dv_q[ROM_LATENCY-1];
            out_bin_q   <= bin_d;
            out_sof_q   <= dv_q[ROM_LATENCY-1] & ds_q[ROM_LATENCY-1];
            out_eof_q   <= dv_q[ROM_LATENCY-1] & de_q[ROM_LATENCY-1];
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign err_sync  = err_q;

endmodule

// File: tb/tb_threshold_binarizer.sv
// tb/tb_threshold_binarizer.sv - directed table-driven bench for threshold_binarizer
module tb_threshold_binarizer;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_pixel = 8'h00;
    logic [13:0] rom_addr;
    logic [7:0]  rom_q;
    logic        out_valid, out_bin, out_sof, out_eof, err_sync;
`ifdef THRESH_OFFSET_EN
    logic [8:0]  thr_offset = 9'd0;
`endif

    logic [7:0] mem [N];
    logic [7:0] r1, r2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two-cycle-latency ROM model
    always @(posedge clk) begin
        r1 <= mem[rom_addr];
        r2 <= r1;
    end
    assign rom_q = r2;

    threshold_binarizer #(
        .ADDR_W(14), .PIX_W(8), .NUM_PIXELS(N), .ROM_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .rom_addr(rom_addr), .rom_q(rom_q),
`ifdef THRESH_OFFSET_EN
        .thr_offset(thr_offset),
`endif
        .out_valid(out_valid), .out_bin(out_bin), .out_sof(out_sof),
        .out_eof(out_eof), .err_sync(err_sync)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  p;
        logic [13:0] addr;
        logic        ov;
        logic        ob;
        logic        os;
        logic        oe;
        logic        err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, return at the falling edge
    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] p);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_sof = s; in_pixel = p;
        @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_bin"},   out_bin,   1'b0);
        chk({tag, "_sof"},   out_sof,   1'b0);
        chk({tag, "_eof"},   out_eof,   1'b0);
    endtask

    initial begin
        int addr_bad, out_bad, out_cnt, first_v;
        for (int a = 0; a < N; a++) mem[a] = 8'(a);

        // Reset held with in_valid toggling
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'(c % 2), 1'(c == 1), 8'hAA);
            chk_outs_zero($sformatf("rst%0d", c));
            chk($sformatf("rst%0d_err", c), err_sync, 1'b0);
            chk($sformatf("rst%0d_addr", c), rom_addr, 14'd0);
        end

        // Pixels before any sof are dropped and flag an error
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("presof_err", err_sync, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("presof_nov%0d", c), out_valid, 1'b0);
        end
        chk("presof_addr", rom_addr, 14'd0);

        // Equality/extremes, gaps and sof restart through the vector table
        step(1'b1, 1'b0, 1'b0, 8'h00);
        mem[0] = 8'h40; mem[1] = 8'hFF; mem[2] = 8'h00; mem[3] = 8'h10;
        tbl[0]  = '{1'b1, 1'b1, 8'h40, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 14'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 14'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'hFF, 14'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h01, 14'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 14'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h80, 14'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 14'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 14'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 14'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 14'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h80, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 14'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 14'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 14'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tbl[i].v, tbl[i].s, tbl[i].p);
            chk($sformatf("tbl%0d_addr", i),  rom_addr,  tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_bin", i),   out_bin,   tbl[i].ob);
            chk($sformatf("tbl%0d_sof", i),   out_sof,   tbl[i].os);
            chk($sformatf("tbl%0d_eof", i),   out_eof,   tbl[i].oe);
            chk($sformatf("tbl%0d_err", i),   err_sync,  tbl[i].err);
        end

        // Full frame: threshold = addr[7:0], pixel 128 everywhere
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int a = 0; a < 4; a++) mem[a] = 8'(a);
        addr_bad = 0; out_bad = 0; out_cnt = 0; first_v = -1;
        for (int c = 0; c < N + 5; c++) begin
            int idx;
            logic ev, eb, es, ee;
            step(1'b0, 1'(c < N), 1'(c == 0), 8'd128);
            if (c < N && rom_addr !== 14'(c)) addr_bad++;
            idx = c - 3;
            ev = (idx >= 0) && (idx < N);
            eb = ev && ((idx % 256) < 128);
            es = ev && (idx == 0);
            ee = ev && (idx == N - 1);
            if (out_valid) begin
                out_cnt++;
                if (first_v < 0) first_v = c;
            end
            if (out_valid !== ev || out_bin !== eb || out_sof !== es || out_eof !== ee) begin
                if (out_bad == 0)
                    $display("full frame first bad output at cycle %0d idx %0d", c, idx);
                out_bad++;
            end
        end
        chk("frame_addr_bad", 32'(addr_bad), 32'd0);
        chk("frame_out_bad", 32'(out_bad), 32'd0);
        chk("frame_out_count", 32'(out_cnt), 32'(N));
        chk("frame_first_valid", 32'(first_v), 32'd3);
        chk("frame_err", err_sync, 1'b0);
        chk("frame_idle_addr", rom_addr, 14'd0);

        // Back in IDLE: a sof-less pixel is dropped
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_err", err_sync, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_nov", out_valid, 1'b0);

        // Restart with sof at index 100
        for (int c = 0; c < 106; c++) begin
            step(1'b0, 1'b1, 1'(c == 0 || c == 100), 8'd128);
            if (c == 99)  chk("mid_addr99", rom_addr, 14'd99);
            if (c == 100) chk("mid_addr_sof", rom_addr, 14'd0);
            if (c == 101) chk("mid_addr_next", rom_addr, 14'd1);
            if (c == 102) chk("mid_nosof", out_sof, 1'b0);
            if (c == 103) begin
                chk("mid_valid", out_valid, 1'b1);
                chk("mid_sof", out_sof, 1'b1);
            end
        end
        chk("mid_err", err_sync, 1'b1);

        // Reset mid-frame drops in-flight pixels
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rmid_err", err_sync, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("rmid_nov%0d", c), out_valid, 1'b0);
        end

`ifdef THRESH_OFFSET_EN
        // Offset saturation at both ends
        step(1'b1, 1'b0, 1'b0, 8'h00);
        mem[0] = 8'hF0; mem[1] = 8'h10;
        thr_offset = 9'sd40;
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("off_hi_valid", out_valid, 1'b1);
        chk("off_hi_bin", out_bin, 1'b0);
        thr_offset = -9'sd40;
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("off_lo_valid", out_valid, 1'b1);
        chk("off_lo_bin", out_bin, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
